// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants.
//   NOP_INST      : canonical RV32I NOP (addi x0,x0,0)
//   INST_W        : instruction word width
//   fetch_state_e : prefetch controller states
//   fetch_entry_t : one buffered {pc, inst} pair
//   fetch_dbg_t   : observable controller state for checkers
package riscv_pkg;

    localparam int          INST_W   = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Counter fields are wide enough for the largest supported DEPTH (16).
    typedef struct packed {
        fetch_state_e state;
        logic [4:0]   outstanding;
        logic [4:0]   discard;
        logic [4:0]   count;
    } fetch_dbg_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous in-order FIFO with synchronous clear and occupancy count.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear_i       : empty the FIFO next cycle; dominates push and pop
//   push_i        : write push_data_i at the tail (dropped when full
//                   unless a pop happens in the same cycle)
//   pop_i         : remove the head entry (ignored when empty)
//   head_o        : current head entry (contents undefined when empty)
//   count_o       : number of valid entries
//   empty_o       : count_o == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction-fetch front end feeding the IF/ID register.
// Issues sequential word-aligned fetches to instruction memory, buffers the
// returned {pc, inst} pairs in order and presents them to IF/ID.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   redirect_i/redirect_pc_i: taken control transfer; flush and refetch
//   imem_req_o/imem_addr_o  : fetch request and its word address
//   imem_gnt_i              : request accepted (only while imem_req_o=1)
//   imem_rvalid_i/rdata_i   : in-order response data
//   inst_valid_o/inst_o/pc_o: FIFO head (NOP / 0 when not valid)
//   inst_ready_i            : IF/ID accepts; low stalls on a hazard
//   err_o                   : sticky, response seen with nothing outstanding
//   dbg_o                   : controller state, outstanding, discard, count
//
// Handshakes: a fetch is accepted on a cycle with imem_req_o && imem_gnt_i;
// imem_req_o may drop without a grant. An instruction transfers to IF/ID on
// a cycle with inst_valid_o && inst_ready_i; the head stays stable until then
// except when a redirect flushes it.
module if_prefetch_buffer
    import riscv_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    input  logic        inst_ready_i,
    output logic        err_o,
    output fetch_dbg_t  dbg_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_clear;
    logic [63:0]      head_raw;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    logic             redirect_act;
    logic             rsp_ok;
    logic             rsp_spurious;
    logic             room;
    logic             req;
    logic             fire;
    logic [31:0]      redirect_pc_al;

    assign redirect_pc_al = redirect_pc_i & ~32'h3;
    assign redirect_act   = redirect_i && (state_q != BOOT);
    assign rsp_ok         = imem_rvalid_i && (outst_q != '0);
    assign rsp_spurious   = imem_rvalid_i && (outst_q == '0);

    // Counting in-flight requests against FIFO space means every response
    // already has a slot reserved, so the FIFO can never overflow.
    assign room = (({1'b0, fifo_count} + {1'b0, outst_q}) < (CNT_W + 1)'(DEPTH))
               && (outst_q < CNT_W'(MAX_OUTSTANDING));
    assign req  = (state_q == FETCH) && room && !redirect_i;
    assign fire = req && imem_gnt_i;

    assign fifo_clear = redirect_act;
    // Responses owed to a flushed stream, or arriving alongside a redirect,
    // never enter the FIFO.
    assign fifo_push  = rsp_ok && (discard_q == '0) && !redirect_act;
    assign fifo_pop   = !fifo_empty && inst_ready_i && !redirect_act;
    assign push_entry = '{pc: resp_pc_q, inst: imem_rdata_i};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        outst_d    = outst_q + CNT_W'(fire) - CNT_W'(rsp_ok);
        err_d      = err_q | rsp_spurious;

        if (fire) fetch_pc_d = fetch_pc_q + 32'd4;

        if (rsp_ok) begin
            if (discard_q != '0) discard_d = discard_q - CNT_W'(1);
            else                 resp_pc_d = resp_pc_q + 32'd4;
        end

        unique case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            // Leave one cycle after the last stale response has drained.
            FLUSH:   if (discard_q == '0) state_d = FETCH;
            default: state_d = BOOT;
        endcase

        // Every response still in flight after this cycle belongs to the old
        // stream; a redirect during FLUSH only retargets, as the in-flight
        // total already equals the remaining discard count.
        if (redirect_act) begin
            fetch_pc_d = redirect_pc_al;
            resp_pc_d  = redirect_pc_al;
            discard_d  = outst_q - CNT_W'(rsp_ok);
            state_d    = (discard_d != '0) ? FLUSH : FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            err_q      <= err_d;
        end
    end

    if_fifo #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (fifo_clear),
        .push_i     (fifo_push),
        .push_data_i(push_entry),
        .pop_i      (fifo_pop),
        .head_o     (head_raw),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty)
    );

    assign head = fetch_entry_t'(head_raw);

    assign imem_req_o   = req;
    assign imem_addr_o  = fetch_pc_q;
    assign inst_valid_o = !fifo_empty;
    assign inst_o       = fifo_empty ? NOP_INST : head.inst;
    assign pc_o         = fifo_empty ? 32'h0 : head.pc;
    assign err_o        = err_q;

    always_comb begin
        dbg_o             = '0;
        dbg_o.state       = state_q;
        dbg_o.outstanding = 5'(outst_q);
        dbg_o.discard     = 5'(discard_q);
        dbg_o.count       = 5'(fifo_count);
    end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
module tb_if_prefetch_buffer;
    import riscv_pkg::*;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_ready_i = 1'b0;
    logic        err_o;
    fetch_dbg_t  dbg_o;

    always #5 clk = ~clk;

    if_prefetch_buffer #(
        .DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAX_OUT),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .inst_ready_i (inst_ready_i),
        .err_o        (err_o),
        .dbg_o        (dbg_o)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [63:0] exp_q[$];       // expected FIFO contents {pc, inst}
    logic [31:0] infl_addr[$];   // granted, not yet returned
    int          infl_due[$];
    bit          infl_live[$];   // 0 = belongs to a flushed stream
    logic [31:0] pop_log[$];
    logic [31:0] grant_log[$];
    logic [31:0] model_pc;
    logic        model_err;
    int          cyc;
    int          first_valid;
    int          ready_mode;     // 0 stall, 1 always ready, 2 random
    int          gnt_mode;       // 0 always grant, 1 random
    int          extra_min;
    int          extra_max;
    bit          last_redir;
    int          max_outst;
    int          max_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[15:8], ~a[23:16], a[31:24]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        inst_ready_i  = 1'b0;
        #1;
        check("rst_valid", inst_valid_o, 0);
        check("rst_req", imem_req_o, 0);
        check("rst_err", err_o, 0);
        check("rst_inst", inst_o, NOP_INST);
        check("rst_pc", pc_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", dbg_o.state, BOOT);
        exp_q.delete();
        infl_addr.delete();
        infl_due.delete();
        infl_live.delete();
        pop_log.delete();
        grant_log.delete();
        model_pc    = 32'h0;
        model_err   = 1'b0;
        cyc         = 0;
        first_valid = -1;
        last_redir  = 1'b0;
        rst_n       = 1'b1;
    endtask

    // One clock cycle, entered and left just after a falling edge.
    // redir_mode: 0 none, 1 redirect now, 2 redirect only if rvalid this cycle.
    task automatic cycle(input int redir_mode, input logic [31:0] rpc, input bit spurious);
        logic        rdy, rv, redir, req, gnt;
        logic [31:0] a;
        int          d, dead;
        bit          live;

        if (first_valid < 0 && inst_valid_o) first_valid = cyc;
        check("valid", inst_valid_o, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("head_pc", pc_o, exp_q[0][63:32]);
            check("head_inst", inst_o, exp_q[0][31:0]);
        end else begin
            check("idle_pc", pc_o, 0);
            check("idle_inst", inst_o, NOP_INST);
        end
        check("count", dbg_o.count, exp_q.size());
        check("outstanding", dbg_o.outstanding, infl_addr.size());
        check("err", err_o, model_err);
        if (int'(dbg_o.outstanding) > max_outst) max_outst = int'(dbg_o.outstanding);
        if (int'(dbg_o.count) > max_cnt) max_cnt = int'(dbg_o.count);

        case (ready_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            default: rdy = ($urandom_range(0, 3) != 0);
        endcase
        rv    = spurious || (infl_addr.size() != 0 && infl_due[0] <= cyc);
        redir = (redir_mode == 1) || (redir_mode == 2 && rv);
        last_redir = redir;

        redirect_i    = redir;
        redirect_pc_i = rpc;
        inst_ready_i  = rdy;
        imem_rvalid_i = rv;
        imem_rdata_i  = spurious ? 32'hDEAD_BEEF :
                        (infl_addr.size() != 0 ? mem_word(infl_addr[0]) : 32'h0);
        imem_gnt_i    = 1'b0;
        #1;
        req = imem_req_o;
        if (redir) check("req_on_redirect", req, 0);
        if (req) begin
            dead = 0;
            foreach (infl_live[i]) if (!infl_live[i]) dead++;
            check("req_while_flushing", dead, 0);
            check("req_room", (exp_q.size() + infl_addr.size() < DEPTH) && (infl_addr.size() < MAX_OUT), 1);
            check("req_addr", imem_addr_o, model_pc);
        end
        gnt = req && (gnt_mode == 0 || $urandom_range(0, 1) == 1);
        imem_gnt_i = gnt;
        #1;

        // Model update for the coming rising edge.
        if (exp_q.size() != 0 && rdy) begin
            pop_log.push_back(exp_q[0][63:32]);
            void'(exp_q.pop_front());
        end
        if (rv) begin
            if (infl_addr.size() != 0) begin
                a    = infl_addr.pop_front();
                d    = infl_due.pop_front();
                live = infl_live.pop_front();
                if (live) exp_q.push_back({a, mem_word(a)});
            end else begin
                model_err = 1'b1;
            end
        end
        if (gnt) begin
            grant_log.push_back(model_pc);
            infl_addr.push_back(model_pc);
            infl_due.push_back(cyc + 1 + int'($urandom_range(extra_max, extra_min)));
            infl_live.push_back(1'b1);
            model_pc = model_pc + 32'd4;
        end
        if (redir) begin
            foreach (infl_live[i]) infl_live[i] = 1'b0;
            exp_q.delete();
            model_pc = rpc & ~32'h3;
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // ---------------- directed and random stimulus ----------------
    int gl0;

    initial begin
        max_outst = 0;
        max_cnt   = 0;

        // 1: streaming with single-cycle memory
        ready_mode = 1; gnt_mode = 0; extra_min = 0; extra_max = 0;
        do_reset();
        repeat (10) cycle(0, 32'h0, 1'b0);
        check("t1_first_valid_cycle", first_valid, 3);
        check("t1_pop_count", pop_log.size(), 7);
        for (int i = 0; i < 4; i++)
            check("t1_pop_pc", (i < pop_log.size()) ? pop_log[i] : 32'hFFFF_FFFF, 32'(i * 4));

        // 2: hazard stall fills the FIFO, then drains back to back
        ready_mode = 0;
        do_reset();
        repeat (20) cycle(0, 32'h0, 1'b0);
        check("t2_count_full", dbg_o.count, DEPTH);
        check("t2_req_low", imem_req_o, 0);
        check("t2_outst_zero", dbg_o.outstanding, 0);
        ready_mode = 1;
        pop_log.delete();
        repeat (4) cycle(0, 32'h0, 1'b0);
        check("t2_pop_count", pop_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t2_pop_pc", (i < pop_log.size()) ? pop_log[i] : 32'hFFFF_FFFF, 32'(i * 4));
        repeat (4) cycle(0, 32'h0, 1'b0);
        check("t2_resume_addr", (grant_log.size() > 4) ? grant_log[4] : 32'hFFFF_FFFF, 32'h10);

        // 3: redirect with two requests in flight
        do_reset();
        for (int i = 0; i < 60 && model_pc != 32'h20; i++) cycle(0, 32'h0, 1'b0);
        check("t3_reach_20", model_pc, 32'h20);
        extra_min = 4; extra_max = 4;
        for (int i = 0; i < 30 && model_pc != 32'h28; i++) cycle(0, 32'h0, 1'b0);
        check("t3_reach_28", model_pc, 32'h28);
        check("t3_outst_two", dbg_o.outstanding, 2);
        gl0 = grant_log.size();
        cycle(1, 32'h103, 1'b0);
        check("t3_state_flush", dbg_o.state, FLUSH);
        check("t3_discard", dbg_o.discard, 2);
        extra_min = 0; extra_max = 0;
        pop_log.delete();
        repeat (15) cycle(0, 32'h0, 1'b0);
        check("t3_first_grant", (grant_log.size() > gl0) ? grant_log[gl0] : 32'hFFFF_FFFF, 32'h100);
        check("t3_first_pop", (pop_log.size() > 0) ? pop_log[0] : 32'hFFFF_FFFF, 32'h100);

        // 4: redirect alongside rvalid, then retarget during FLUSH
        extra_min = 3; extra_max = 3;
        do_reset();
        for (int i = 0; i < 30 && !last_redir; i++)
            cycle((infl_addr.size() == 2) ? 2 : 0, 32'h180, 1'b0);
        check("t4_redirect_taken", last_redir, 1);
        check("t4_state_flush", dbg_o.state, FLUSH);
        check("t4_discard", dbg_o.discard, 1);
        pop_log.delete();
        cycle(1, 32'h200, 1'b0);
        repeat (12) cycle(0, 32'h0, 1'b0);
        check("t4_state_fetch", dbg_o.state, FETCH);
        check("t4_first_pop", (pop_log.size() > 0) ? pop_log[0] : 32'hFFFF_FFFF, 32'h200);

        // 6: spurious response with nothing outstanding
        ready_mode = 0; extra_min = 0; extra_max = 0;
        do_reset();
        repeat (20) cycle(0, 32'h0, 1'b0);
        cycle(0, 32'h0, 1'b1);
        check("t6_err_set", err_o, 1);
        check("t6_count_kept", dbg_o.count, DEPTH);
        check("t6_head_kept", pc_o, 32'h0);
        cycle(1, 32'h300, 1'b0);
        repeat (5) cycle(0, 32'h0, 1'b0);
        check("t6_err_sticky", err_o, 1);

        // 5: random memory timing, stalls and redirects
        ready_mode = 2; gnt_mode = 1; extra_min = 0; extra_max = 5;
        do_reset();
        max_outst = 0;
        max_cnt   = 0;
        pop_log.delete();
        for (int i = 0; i < 3000; i++)
            cycle((cyc > 2 && $urandom_range(0, 39) == 0) ? 1 : 0, $urandom, 1'b0);
        check("t5_max_outst", max_outst <= MAX_OUT, 1);
        check("t5_max_count", max_cnt <= DEPTH, 1);
        check("t5_progress", pop_log.size() > 100, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_prefetch_buffer.md
Name: if_prefetch_buffer

Overview:
Instruction-fetch front end that sits directly upstream of the IF/ID register. It generates sequential fetch addresses and issues them to instruction memory over a req/gnt/rvalid handshake. Returned {pc, inst} pairs are buffered in a small in-order FIFO and presented to IF/ID with valid/ready. Control-transfer redirects flush the FIFO and discard any responses still in flight; a load-use hazard stall is applied by deasserting ready.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
MAX_OUTSTANDING, 2, maximum granted but not yet returned imem requests (1..DEPTH)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
redirect_i  in  1  taken branch/jump; flush and refetch from redirect_pc_i
redirect_pc_i  in  32  redirect target; bits [1:0] are forced to 0 internally
imem_req_o  out  1  fetch request valid
imem_addr_o  out  32  fetch address, word aligned
imem_gnt_i  in  1  request accepted this cycle (only meaningful while req=1)
imem_rvalid_i  in  1  response valid; responses return in request order, at least 1 cycle after gnt
imem_rdata_i  in  32  instruction word
inst_valid_o  out  1  FIFO head valid
inst_o  out  32  head instruction; 32'h0000_0013 (NOP) when not valid
pc_o  out  32  head PC; 0 when not valid
inst_ready_i  in  1  IF/ID accepts; low = hazard stall
err_o  out  1  sticky; rvalid received with zero outstanding requests

Behaviour:
- Reset (async): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=BOOT; imem_req_o=0, inst_valid_o=0, inst_o=NOP, pc_o=0, err_o=0.
- FSM states:
  - BOOT: one cycle, then FETCH.
  - FETCH: normal operation.
  - FLUSH: entered on a redirect while discard>0 after the update; returns to FETCH in the cycle after discard reaches 0.
- Issue rule, FETCH only:
  - imem_req_o = (count + outstanding < DEPTH) and (outstanding < MAX_OUTSTANDING) and !redirect_i.
  - imem_addr_o = fetch_pc.
  - req and gnt in the same cycle: fetch_pc += 4 (mod 2^32 wrap), outstanding += 1.
  - req may drop without gnt (e.g. on redirect); imem tolerates this.
- Response:
  - rvalid: outstanding -= 1.
  - If discard>0: discard -= 1, data dropped.
  - Otherwise push {resp_pc, rdata}, where resp_pc is a separate counter that tracks the PC of the oldest outstanding request.
  - Gnt and rvalid in the same cycle net outstanding by 0.
- Latency:
  - rvalid in cycle N gives inst_valid_o=1 in cycle N+1 (registered FIFO, no bypass).
  - Minimum fetch-to-output: gnt in cycle 0, rvalid in cycle 1, valid in cycle 2.
- Output: pop when inst_valid_o & inst_ready_i. Push and pop in the same cycle is allowed at any occupancy. The issue rule guarantees no overflow.
- Redirect, any state except BOOT:
  - FIFO cleared next cycle; inst_valid_o=0 next cycle even if a pop happens in the redirect cycle.
  - fetch_pc and resp_pc = {redirect_pc_i[31:2],2'b00}.
  - discard = outstanding after this cycle's rvalid is accounted. A response arriving in the redirect cycle is itself dropped.
  - No request is issued in the redirect cycle.
  - Redirect during FLUSH: retarget only; discard keeps counting the original in-flight responses.
- Redirect with outstanding=0: go straight to FETCH; the first request goes out the next cycle.
- rvalid while outstanding=0: ignored, err_o set until reset.
- Reset mid-operation clears everything asynchronously. Responses from before reset are not tracked; imem is assumed to be reset by the same rst_n.

Decomposition:
- Shared package (riscv_pkg): NOP_INST=32'h0000_0013, INST_W=32, fetch_state_e {BOOT, FETCH, FLUSH}, and the fetch_entry_t struct {pc, inst}.
- One sub-module: if_fifo (parameterised sync FIFO with clear, count, push/pop), reusable for a later store buffer.

Test Plan:
1. Reset, imem grants every request with 1-cycle response, ready=1 -> pc_o sequence 0,4,8,C..., first inst_valid_o in cycle 3 after rst_n release; inst_o matches the memory image.
2. ready=0 for 20 cycles -> count saturates at DEPTH=4, imem_req_o=0, outstanding=0; ready=1 -> 4 back-to-back pops (0x0..0xC), then fetch resumes at 0x10.
3. Two requests granted (0x20, 0x24), redirect_i with target 0x103 before the responses -> both responses dropped, next req addr 0x100, first valid output pc_o=0x100.
4. Redirect in the same cycle as an rvalid, then a second redirect to 0x200 while in FLUSH -> no stale instruction is output, FSM returns to FETCH, pc_o=0x200.
5. Random gnt/rvalid delays of 0-5 cycles with random ready, checked against a reference model -> in-order, no loss or duplication, outstanding never exceeds 2, count never exceeds 4.
6. Spurious rvalid with nothing outstanding -> err_o=1 and stays 1 across a later redirect; FIFO contents unchanged.
